prog_sequencer: RTL and testbench

PROG_SEQUENCER -- requirements
Module: prog_sequencer

---
 rtl/seq_pkg.sv | 18 +
 rtl/edge_detect.sv | 18 +
 rtl/prog_sequencer.sv | 141 ++++++++++++++
 tb/tb_prog_sequencer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and default timing constants for the program sequencer.
package seq_pkg;

   localparam int NPROG_DEF        = 3;
   localparam int RST_CYCLES_DEF   = 4;
   localparam int START_CYCLES_DEF = 2;
   localparam int TIMEOUT_DEF      = 1000;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST_CPU,
      S_START_HI,
      S_RUN,
      S_REPORT,
      S_DONE
   } seq_state_t;

endpackage

// File: rtl/edge_detect.sv
// Registered rising-edge detector: holds last sample, flags 0->1.
module edge_detect (
   input  logic Clk,
   input  logic Reset,
   input  logic sig,
   output logic rise
);

   logic sig_r;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) sig_r <= 1'b0;
      else        sig_r <= sig;
   end

   assign rise = sig & ~sig_r;

endmodule

// File: rtl/prog_sequencer.sv
// Drives CPU reset/start for NPROG programs and reports RUN cycle counts.
module prog_sequencer
   import seq_pkg::*;
#(
   parameter int NPROG        = NPROG_DEF,
   parameter int RST_CYCLES   = RST_CYCLES_DEF,
   parameter int START_CYCLES = START_CYCLES_DEF,
   parameter int TIMEOUT      = TIMEOUT_DEF
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Go,
   input  logic        Ack,
   output logic        CpuReset,
   output logic        Start,
   output logic [1:0]  ProgIdx,
   output logic [15:0] CycleCount,
   output logic        CountValid,
   output logic        TimedOut,
   output logic        AllDone
);

   seq_state_t  state, state_n;
   logic [15:0] tmr, tmr_n;
   logic [15:0] run_cnt, run_n;
   logic [15:0] cnt_inc;
   logic [15:0] cnt_n;
   logic [1:0]  idx_n;
   logic        to_n;
   logic        ack_rise;
   logic        go_rise;

   edge_detect u_ack_ed (
      .Clk   (Clk),
      .Reset (Reset),
      .sig   (Ack),
      .rise  (ack_rise)
   );

   edge_detect u_go_ed (
      .Clk   (Clk),
      .Reset (Reset),
      .sig   (Go),
      .rise  (go_rise)
   );

   // Count reported is the RUN cycle just completed, saturating.
   assign cnt_inc = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;

   always_comb begin
      state_n = state;
      tmr_n   = tmr;
      run_n   = run_cnt;
      idx_n   = ProgIdx;
      cnt_n   = CycleCount;
      to_n    = TimedOut;
      unique case (state)
         S_IDLE: begin
            if (Go) begin
               state_n = S_RST_CPU;
               tmr_n   = '0;
            end
         end
         S_RST_CPU: begin
            if (tmr == 16'(RST_CYCLES - 1)) begin
               state_n = S_START_HI;
               tmr_n   = '0;
               idx_n   = 2'd1;
            end else begin
               tmr_n = tmr + 16'd1;
            end
         end
         S_START_HI: begin
            if (tmr == 16'(START_CYCLES - 1)) begin
               state_n = S_RUN;
               run_n   = '0;
            end else begin
               tmr_n = tmr + 16'd1;
            end
         end
         S_RUN: begin
            if (ack_rise) begin
               state_n = S_REPORT;
               cnt_n   = cnt_inc;
               to_n    = 1'b0;
            end else if (cnt_inc == 16'(TIMEOUT)) begin
               state_n = S_REPORT;
               cnt_n   = cnt_inc;
               to_n    = 1'b1;
            end else begin
               run_n = cnt_inc;
            end
         end
         S_REPORT: begin
            if (ProgIdx < 2'(NPROG)) begin
               state_n = S_START_HI;
               tmr_n   = '0;
               idx_n   = ProgIdx + 2'd1;
            end else begin
               state_n = S_DONE;
            end
         end
         S_DONE: begin
            if (go_rise) begin
               state_n = S_RST_CPU;
               tmr_n   = '0;
               idx_n   = 2'd0;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Strobes are registered from the next state so outputs align with it.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state      <= S_IDLE;
         tmr        <= '0;
         run_cnt    <= '0;
         ProgIdx    <= '0;
         CycleCount <= '0;
         TimedOut   <= 1'b0;
         CpuReset   <= 1'b0;
         Start      <= 1'b0;
         CountValid <= 1'b0;
         AllDone    <= 1'b0;
      end else begin
         state      <= state_n;
         tmr        <= tmr_n;
         run_cnt    <= run_n;
         ProgIdx    <= idx_n;
         CycleCount <= cnt_n;
         TimedOut   <= to_n;
         CpuReset   <= (state_n == S_RST_CPU);
         Start      <= (state_n == S_START_HI);
         CountValid <= (state_n == S_REPORT);
         AllDone    <= (state_n == S_DONE);
      end
   end

endmodule

// File: tb/tb_prog_sequencer.sv
// Self-checking bench for prog_sequencer: vector table plus report scoreboard.
module tb_prog_sequencer;

   logic        Clk;
   logic        Reset;
   logic        Go;
   logic        Ack;
   logic        CpuReset;
   logic        Start;
   logic [1:0]  ProgIdx;
   logic [15:0] CycleCount;
   logic        CountValid;
   logic        TimedOut;
   logic        AllDone;

   prog_sequencer dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .Go         (Go),
      .Ack        (Ack),
      .CpuReset   (CpuReset),
      .Start      (Start),
      .ProgIdx    (ProgIdx),
      .CycleCount (CycleCount),
      .CountValid (CountValid),
      .TimedOut   (TimedOut),
      .AllDone    (AllDone)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      int          ack_dly;
      logic [15:0] exp_cnt;
      logic        exp_to;
   } vec_t;

   typedef struct packed {
      logic [15:0] cnt;
      logic        to;
      logic [1:0]  idx;
   } exp_t;

   vec_t vt [0:6];
   exp_t sb [$];
   int   n_cmp = 0;
   int   n_bad = 0;
   logic cv_prev = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Report monitor: every CountValid pops one expected result.
   always @(negedge Clk) begin
      if (Reset && CountValid) begin
         if (sb.size() == 0) begin
            chk("spurious_countvalid", CountValid, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("cycle_count", CycleCount, e.cnt);
            chk("timed_out", TimedOut, e.to);
            chk("report_idx", ProgIdx, e.idx);
         end
      end
      if (cv_prev && CountValid) chk("countvalid_width", CountValid, 0);
      cv_prev = CountValid;
   end

   task automatic start_phase();
      int g;
      int n;
      g = 0;
      do begin
         @(negedge Clk);
         g++;
      end while (!CpuReset && g < 10);
      chk("cpureset_seen", CpuReset, 1);
      chk("progidx_in_rst", ProgIdx, 0);
      chk("alldone_in_rst", AllDone, 0);
      n = 0;
      while (CpuReset && n < 20) begin
         n++;
         @(negedge Clk);
      end
      chk("cpureset_len", n, 4);
      chk("start_after_rst", Start, 1);
      chk("progidx_first", ProgIdx, 1);
      n = 0;
      while (Start && n < 20) begin
         n++;
         @(negedge Clk);
      end
      chk("start_len", n, 2);
   endtask

   // Entered at the negedge just after Start fell (first RUN cycle).
   task automatic prog(input vec_t v, input int idx);
      int g;
      int n;
      sb.push_back({v.exp_cnt, v.exp_to, 2'(idx)});
      if (v.ack_dly > 0) begin
         repeat (v.ack_dly - 1) @(negedge Clk);
         Ack = 1'b1;
      end
      g = 0;
      while (!CountValid && g < 1200) begin
         @(negedge Clk);
         g++;
      end
      chk("report_seen", CountValid, 1);
      Ack = 1'b0;
      if (idx < 3) begin
         @(negedge Clk);
         chk("restart_start", Start, 1);
         chk("progidx_next", ProgIdx, idx + 1);
         n = 0;
         while (Start && n < 20) begin
            n++;
            @(negedge Clk);
         end
         chk("start_len_next", n, 2);
      end
   endtask

   task automatic wait_done();
      int g;
      int viol;
      g = 0;
      while (!AllDone && g < 10) begin
         @(negedge Clk);
         g++;
      end
      chk("alldone", AllDone, 1);
      viol = 0;
      repeat (6) begin
         @(negedge Clk);
         if (!AllDone || Start || CpuReset || ProgIdx != 2'd3) viol++;
      end
      chk("done_hold", viol, 0);
   endtask

   initial begin
      int nz;
      vt[0] = '{37,   16'd37,   1'b0};
      vt[1] = '{0,    16'd1000, 1'b1};
      vt[2] = '{1000, 16'd1000, 1'b0};
      vt[3] = '{1,    16'd1,    1'b0};
      vt[4] = '{5,    16'd5,    1'b0};
      vt[5] = '{2,    16'd2,    1'b0};
      vt[6] = '{3,    16'd3,    1'b0};

      Reset = 1'b0;
      Go    = 1'b0;
      Ack   = 1'b0;
      repeat (3) @(negedge Clk);
      chk("reset_outputs",
          {CpuReset, Start, ProgIdx, CycleCount, CountValid, TimedOut, AllDone}, 0);
      Reset = 1'b1;
      repeat (3) @(negedge Clk);
      chk("idle_without_go",
          {CpuReset, Start, ProgIdx, CycleCount, CountValid, TimedOut, AllDone}, 0);

      // Sequence 1: normal ack, timeout, ack on the timeout cycle.
      Go = 1'b1;
      start_phase();
      for (int i = 0; i < 3; i++) prog(vt[i], i + 1);
      wait_done();

      // Sequence 2: restart from DONE needs a Go rising edge.
      Go = 1'b0;
      repeat (2) @(negedge Clk);
      Go = 1'b1;
      start_phase();
      for (int i = 3; i < 6; i++) prog(vt[i], i - 2);
      wait_done();

      // Sequence 3: reset asserted mid-RUN of program 2.
      Go = 1'b0;
      repeat (2) @(negedge Clk);
      Go = 1'b1;
      start_phase();
      prog(vt[6], 1);
      repeat (10) @(negedge Clk);
      #2 Reset = 1'b0;
      #1;
      chk("async_reset_outputs",
          {CpuReset, Start, ProgIdx, CycleCount, CountValid, TimedOut, AllDone}, 0);
      Go = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      nz = 0;
      repeat (4) begin
         Ack = 1'b1;
         repeat (2) begin
            @(negedge Clk);
            if ({CpuReset, Start, ProgIdx, CountValid, AllDone} != 0) nz++;
         end
         Ack = 1'b0;
         repeat (2) begin
            @(negedge Clk);
            if ({CpuReset, Start, ProgIdx, CountValid, AllDone} != 0) nz++;
         end
      end
      chk("idle_after_reset", nz, 0);
      Go = 1'b1;
      start_phase();
      chk("scoreboard_empty", sb.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
